// File: rtl/apb_completer_regs.sv
// apb_completer_regs: APB4/APB5 completer over NUM_REGS byte-strobed registers with programmable wait states.
// Optional APB_PROT_CHECK_EN: unprivileged (pprot[0]=0) accesses complete with pslverr and no effect.
module apb_completer_regs #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [2:0]                     pprot,
  input  logic                           pnse,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic                           pready,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [3:0]       wcnt;
  logic [IDX_W-1:0] idx;
  logic             mapped, err, commit, unused;
  always_comb begin
    idx     = paddr[LSB +: IDX_W];
    mapped  = int'(idx) < NUM_REGS && (paddr >> (LSB + IDX_W)) == '0;
`ifdef APB_PROT_CHECK_EN
    err     = !mapped || !pprot[0];
`else
    err     = !mapped;
`endif
    pready  = !preset && psel && penable && wcnt == 4'(WAIT_STATES);
    pslverr = pready && err;
    commit  = pready && pwrite && !err;
    prdata  = pready && !pwrite && !err ? regs[idx] : '0;
  end
  // In access without pready, wcnt is necessarily below WAIT_STATES, so no bound check is needed
  always_ff @(posedge pclk) begin
    if (preset) begin
      regs     <= '0;
      wcnt     <= '0;
      wr_pulse <= '0;
    end else begin
      wcnt     <= (!psel || pready) ? 4'd0 : penable ? wcnt + 4'd1 : wcnt;
      wr_pulse <= '0;
      if (commit) begin
        wr_pulse[idx] <= 1'b1;
        for (int b = 0; b < NB; b++)
          if (pstrb[b]) regs[idx][b*8 +: 8] <= pwdata[b*8 +: 8];
      end
    end
  end
  assign regs_q = regs;
  assign unused = ^{pnse, pprot};
endmodule

// File: tb/tb_apb_completer_regs.sv
// tb_apb_completer_regs: table-driven check of a zero-wait instance plus hand sequences on a 3-wait-state instance.
module tb_apb_completer_regs;
`ifdef APB_PROT_CHECK_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif
  logic         clk = 1'b0, preset = 1'b1, preset3 = 1'b1;
  logic [31:0]  paddr = '0, pwdata = '0;
  logic [2:0]   pprot = 3'b001;
  logic         pnse = 1'b0, psel = 1'b0, psel3 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0]   pstrb = '0;
  logic         pready, pslverr, pready3, pslverr3;
  logic [31:0]  prdata, prdata3;
  logic [511:0] regs_q, regs_q3;
  logic [15:0]  wr_pulse, wr_pulse3;
  int n_chk = 0, n_fail = 0;

  apb_completer_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(0)) dut (
    .pclk(clk), .preset(preset), .paddr(paddr), .pprot(pprot), .pnse(pnse), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
    .prdata(prdata), .pslverr(pslverr), .regs_q(regs_q), .wr_pulse(wr_pulse));

  apb_completer_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(3)) dut3 (
    .pclk(clk), .preset(preset3), .paddr(paddr), .pprot(pprot), .pnse(pnse), .psel(psel3),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready3),
    .prdata(prdata3), .pslverr(pslverr3), .regs_q(regs_q3), .wr_pulse(wr_pulse3));

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] wp;
  } vec_t;
  vec_t v[17];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the pulse has had a cycle to clear
  task automatic xfer(input logic wr, input logic [31:0] a, d, input logic [3:0] s, input logic [2:0] p,
                      output logic rdy, err, output logic [31:0] rd, output logic [15:0] wp, wp2);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = p;
    @(negedge clk); penable = 1'b1; #1;
    rdy = pready; err = pslverr; rd = prdata;
    @(negedge clk); psel = 1'b0; penable = 1'b0; wp = wr_pulse;
    @(negedge clk); wp2 = wr_pulse;
  endtask

  task automatic xfer3(input logic wr, input logic [31:0] a, d, output int waits,
                       output logic rdy, err, output logic [31:0] rd, output logic [15:0] wp);
    psel3 = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = 4'hF; pprot = 3'b001;
    @(negedge clk); penable = 1'b1; waits = 0; #1;
    while (!pready3 && waits < 10) begin
      @(negedge clk); #1; waits++;
    end
    rdy = pready3; err = pslverr3; rd = prdata3;
    @(negedge clk); psel3 = 1'b0; penable = 1'b0; wp = wr_pulse3;
    @(negedge clk);
  endtask

  initial begin
    logic rdy, err;
    logic [31:0] rd;
    logic [15:0] wp, wp2;
    logic [511:0] e;
    int waits;
    v[0]  = '{1'b1, 32'h08, 32'hA5A5_1234, 4'hF, 3'b001, 32'h0, 1'b0, 16'h0004};
    v[1]  = '{1'b0, 32'h08, 32'h0, 4'h0, 3'b001, 32'hA5A5_1234, 1'b0, 16'h0};
    v[2]  = '{1'b1, 32'h0C, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0, 1'b0, 16'h0008};
    v[3]  = '{1'b1, 32'h0C, 32'h0000_0000, 4'b0101, 3'b001, 32'h0, 1'b0, 16'h0008};
    v[4]  = '{1'b0, 32'h0C, 32'h0, 4'h0, 3'b001, 32'hFF00_FF00, 1'b0, 16'h0};
    v[5]  = '{1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 3'b001, 32'h0, 1'b1, 16'h0};
    v[6]  = '{1'b0, 32'h40, 32'h0, 4'h0, 3'b001, 32'h0, 1'b1, 16'h0};
    v[7]  = '{1'b1, 32'h3C, 32'h1234_5678, 4'b1000, 3'b001, 32'h0, 1'b0, 16'h8000};
    v[8]  = '{1'b0, 32'h3F, 32'h0, 4'h0, 3'b001, 32'h1200_0000, 1'b0, 16'h0};
    v[9]  = '{1'b1, 32'h10, 32'h1122_3344, 4'h0, 3'b001, 32'h0, 1'b0, 16'h0010};
    v[10] = '{1'b0, 32'h10, 32'h0, 4'h0, 3'b001, 32'h0, 1'b0, 16'h0};
    v[11] = '{1'b1, 32'h1000_0008, 32'h5555_5555, 4'hF, 3'b001, 32'h0, 1'b1, 16'h0};
    v[12] = '{1'b0, 32'h08, 32'h0, 4'h0, 3'b001, 32'hA5A5_1234, 1'b0, 16'h0};
    v[13] = '{1'b1, 32'h04, 32'hCAFE_F00D, 4'hF, 3'b000, 32'h0, PC, PC ? 16'h0 : 16'h0002};
    v[14] = '{1'b0, 32'h04, 32'h0, 4'h0, 3'b001, PC ? 32'h0 : 32'hCAFE_F00D, 1'b0, 16'h0};
    v[15] = '{1'b1, 32'h04, 32'h0BAD_C0DE, 4'hF, 3'b001, 32'h0, 1'b0, 16'h0002};
    v[16] = '{1'b0, 32'h04, 32'h0, 4'h0, 3'b001, 32'h0BAD_C0DE, 1'b0, 16'h0};
    // Reset held while an access is presented: outputs must stay quiet
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pready", {511'b0, pready}, 512'd0);
    chk("rst_pslverr", {511'b0, pslverr}, 512'd0);
    chk("rst_prdata", {480'b0, prdata}, 512'd0);
    chk("rst_wr_pulse", {496'b0, wr_pulse}, 512'd0);
    chk("rst_regs", regs_q, 512'd0);
    @(negedge clk); psel = 1'b0; penable = 1'b0; preset = 1'b0; preset3 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, 32'(i * 4), 32'h0, 4'h0, 3'b001, rdy, err, rd, wp, wp2);
      chk($sformatf("init_rdy%0d", i), {511'b0, rdy}, 512'd1);
      chk($sformatf("init_err%0d", i), {511'b0, err}, 512'd0);
      chk($sformatf("init_rd%0d", i), {480'b0, rd}, 512'd0);
    end
    for (int i = 0; i < 17; i++) begin
      xfer(v[i].wr, v[i].addr, v[i].wdata, v[i].strb, v[i].prot, rdy, err, rd, wp, wp2);
      chk($sformatf("v%0d_rdy", i), {511'b0, rdy}, 512'd1);
      chk($sformatf("v%0d_err", i), {511'b0, err}, {511'b0, v[i].err});
      chk($sformatf("v%0d_rdata", i), {480'b0, rd}, {480'b0, v[i].rdata});
      chk($sformatf("v%0d_wp", i), {496'b0, wp}, {496'b0, v[i].wp});
      chk($sformatf("v%0d_wp_after", i), {496'b0, wp2}, 512'd0);
    end
    e = '0;
    e[1*32 +: 32]  = 32'h0BAD_C0DE;
    e[2*32 +: 32]  = 32'hA5A5_1234;
    e[3*32 +: 32]  = 32'hFF00_FF00;
    e[15*32 +: 32] = 32'h1200_0000;
    chk("final_regs", regs_q, e);
    // Wait-state instance: reset asserted in the second wait cycle abandons the write
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF; pprot = 3'b001;
    @(negedge clk); penable = 1'b1; #1;
    chk("ws_wait1", {511'b0, pready3}, 512'd0);
    @(negedge clk); #1;
    chk("ws_wait2", {511'b0, pready3}, 512'd0);
    chk("ws_wait2_err", {511'b0, pslverr3}, 512'd0);
    preset3 = 1'b1;
    @(negedge clk); preset3 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    chk("ws_rst_regs", regs_q3, 512'd0);
    chk("ws_rst_wp", {496'b0, wr_pulse3}, 512'd0);
    @(negedge clk);
    xfer3(1'b1, 32'h08, 32'h1357_9BDF, waits, rdy, err, rd, wp);
    chk("ws_wr_waits", 512'(waits), 512'd3);
    chk("ws_wr_rdy", {511'b0, rdy}, 512'd1);
    chk("ws_wr_err", {511'b0, err}, 512'd0);
    chk("ws_wr_wp", {496'b0, wp}, 512'h4);
    xfer3(1'b0, 32'h08, 32'h0, waits, rdy, err, rd, wp);
    chk("ws_rd_waits", 512'(waits), 512'd3);
    chk("ws_rd_data", {480'b0, rd}, 512'h1357_9BDF);
    // psel dropped mid-wait: nothing committed and the next transfer waits the full count
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hFFFF_FFFF;
    @(negedge clk); penable = 1'b1;
    repeat (2) @(negedge clk);
    psel3 = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("ws_drop_wp", {496'b0, wr_pulse3}, 512'd0);
    xfer3(1'b0, 32'h0C, 32'h0, waits, rdy, err, rd, wp);
    chk("ws_drop_waits", 512'(waits), 512'd3);
    chk("ws_drop_data", {480'b0, rd}, 512'd0);
    xfer3(1'b0, 32'h40, 32'h0, waits, rdy, err, rd, wp);
    chk("ws_unmap_waits", 512'(waits), 512'd3);
    chk("ws_unmap_err", {511'b0, err}, 512'd1);
    chk("ws_unmap_data", {480'b0, rd}, 512'd0);
    e = '0;
    e[2*32 +: 32] = 32'h1357_9BDF;
    chk("ws_final_regs", regs_q3, e);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
